// File: rtl/gtx_ext_pkg.sv
// Shared types and constants for the GTX extension-board control blocks.
package gtx_ext_pkg;

  localparam int unsigned SPI_STATE_W = 2;

  typedef enum logic [SPI_STATE_W-1:0] {
    IDLE,
    LOW,
    HIGH,
    FINISH
  } spi_state_t;

  localparam logic [7:0] SPI_PORT_ADDR = 8'h01;
  localparam logic [1:0] SPI_DEV       = 2'd1;

endpackage

// File: rtl/half_period_tick.sv
// Loadable down-counter that flags the last CLK cycle of an SCK half-period.
module half_period_tick #(
  parameter  int unsigned DIV = 2,
  localparam int unsigned CW  = $clog2(DIV + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          tick_c
);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tick_c = (cnt == '0);

endmodule

// File: rtl/spi_shift_engine.sv
// Mode-0 SPI byte shifter: one command strobe runs a full MSB-first transfer
// on SCK/MOSI while capturing MISO into RXD.
module spi_shift_engine
  import gtx_ext_pkg::*;
#(
  parameter int unsigned DIV  = 2,
  parameter int unsigned BITS = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CMD_STB,
  input  logic [BITS-1:0] CMD_TXD,
  input  logic            RD_STB,
  input  logic            MISO_IN,
  output logic            SCK,
  output logic            MOSI,
  output logic [BITS-1:0] RXD,
  output logic            BUSY,
  output logic            DONE,
  output logic            OVR
);

  localparam int unsigned DW = $clog2(DIV + 1);
  localparam int unsigned BW = $clog2(BITS + 1);

  spi_state_t      state;
  logic            miso_q;
  logic [BITS-1:0] tx_sr;
  logic [BITS-1:0] rx_sr;
  logic [BW-1:0]   bit_cnt;
  logic            tick_c;
  logic            div_load_c;

  // Reload the half-period timer on command accept and at every SCK edge.
  assign div_load_c = (state == IDLE && CMD_STB) ||
                      ((state == LOW || state == HIGH) && tick_c);

  half_period_tick #(.DIV(DIV)) u_tick (
    .CLK      (CLK),
    .RST      (RST),
    .load     (div_load_c),
    .load_val (DW'(DIV - 1)),
    .tick_c   (tick_c)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      miso_q  <= 1'b0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_cnt <= '0;
      SCK     <= 1'b0;
      MOSI    <= 1'b0;
      RXD     <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      OVR     <= 1'b0;
    end else begin
      miso_q <= MISO_IN;
      DONE   <= 1'b0;

      // A command outside IDLE (FINISH included) is dropped; setting beats clearing.
      if (CMD_STB && state != IDLE) begin
        OVR <= 1'b1;
      end else if (RD_STB) begin
        OVR <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (CMD_STB) begin
            BUSY    <= 1'b1;
            SCK     <= 1'b0;
            MOSI    <= CMD_TXD[BITS-1];
            tx_sr   <= CMD_TXD << 1;
            bit_cnt <= BW'(BITS - 1);
            state   <= LOW;
          end
        end
        LOW: begin
          if (tick_c) begin
            SCK   <= 1'b1;
            rx_sr <= (rx_sr << 1) | BITS'(miso_q);
            state <= HIGH;
          end
        end
        HIGH: begin
          if (tick_c) begin
            SCK <= 1'b0;
            if (bit_cnt != '0) begin
              MOSI    <= tx_sr[BITS-1];
              tx_sr   <= tx_sr << 1;
              bit_cnt <= bit_cnt - BW'(1);
              state   <= LOW;
            end else begin
              RXD   <= rx_sr;
              DONE  <= 1'b1;
              BUSY  <= 1'b0;
              state <= FINISH;
            end
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
